// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel period/high-time with
// shadow registers that are applied only at a period boundary or on sync.
module clk_div_multi #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 13,
    parameter int CH_W       = 2,
    parameter int RST_PERIOD = 1024,
    parameter int RST_HIGH   = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_high,
    output logic [NCH-1:0]   div_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending
);

    localparam logic [CNT_W-1:0] RST_P = CNT_W'(RST_PERIOD);
    localparam logic [CNT_W-1:0] RST_H = CNT_W'(RST_HIGH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] ps_q  [NCH];
    logic [CNT_W-1:0] ps_d  [NCH];
    logic [CNT_W-1:0] hs_q  [NCH];
    logic [CNT_W-1:0] hs_d  [NCH];
    logic [CNT_W-1:0] pa_q  [NCH];
    logic [CNT_W-1:0] pa_d  [NCH];
    logic [CNT_W-1:0] ha_q  [NCH];
    logic [CNT_W-1:0] ha_d  [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [NCH-1:0]   div_q, div_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic [NCH-1:0]   pend_q, pend_d;

    logic             wr_ok;
    logic [CNT_W-1:0] wr_high_clamped;

    always_comb begin
        wr_ok = wr_en && (wr_period >= CNT_W'(2));
        if (wr_high == '0) begin
            wr_high_clamped = ONE;
        end else if (wr_high >= wr_period) begin
            wr_high_clamped = wr_period - ONE;
        end else begin
            wr_high_clamped = wr_high;
        end
    end

    // Boundary handling uses the pre-write shadow; a same-edge write only
    // lands in the shadow and re-arms pending for the following boundary.
    always_comb begin
        div_d  = div_q;
        tick_d = '0;
        pend_d = pend_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            ps_d[i]  = ps_q[i];
            hs_d[i]  = hs_q[i];
            pa_d[i]  = pa_q[i];
            ha_d[i]  = ha_q[i];
            cnt_d[i] = cnt_q[i];
            if (sync || (en && (cnt_q[i] == pa_q[i] - ONE))) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                if (pend_q[i]) begin
                    pa_d[i]   = ps_q[i];
                    ha_d[i]   = hs_q[i];
                    pend_d[i] = 1'b0;
                end
            end else if (en) begin
                cnt_d[i] = cnt_q[i] + ONE;
            end
            if (sync || en) begin
                div_d[i] = (cnt_d[i] < ha_d[i]);
            end
            if (wr_ok && (wr_ch == CH_W'(i))) begin
                ps_d[i]   = wr_period;
                hs_d[i]   = wr_high_clamped;
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                ps_q[i]  <= RST_P;
                hs_q[i]  <= RST_H;
                pa_q[i]  <= RST_P;
                ha_q[i]  <= RST_H;
                cnt_q[i] <= RST_P - ONE;
            end
            div_q  <= '0;
            tick_q <= '0;
            pend_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                ps_q[i]  <= ps_d[i];
                hs_q[i]  <= hs_d[i];
                pa_q[i]  <= pa_d[i];
                ha_q[i]  <= ha_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            div_q  <= div_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign div_out = div_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised and directed bench for clk_div_multi against a position-in-period
// reference model.
module tb_clk_div_multi;

    localparam int NCH   = 4;
    localparam int CNT_W = 13;
    localparam int CH_W  = 2;
    localparam int RP    = 1024;
    localparam int RH    = 512;

    logic             clk = 1'b0;
    logic             rst, en, sync, wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_period, wr_high;
    logic [NCH-1:0]   div_out, tick, pending;

    int checks = 0;
    int passes = 0;

    int mPs [NCH], mHs [NCH], mPa [NCH], mHa [NCH], mPos [NCH];
    bit mPend [NCH], mDiv [NCH], mTick [NCH];

    clk_div_multi #(
        .NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W), .RST_PERIOD(RP), .RST_HIGH(RH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_period(wr_period), .wr_high(wr_high),
        .div_out(div_out), .tick(tick), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mPs[c] = RP; mHs[c] = RH; mPa[c] = RP; mHa[c] = RH;
            mPos[c] = RP - 1; mPend[c] = 0; mDiv[c] = 0; mTick[c] = 0;
        end
    endtask

    // mPos is the position within the current period, advanced modulo Pa.
    task automatic model_edge(input bit e, input bit s, input bit w,
                              input int ch, input int p, input int h);
        for (int c = 0; c < NCH; c++) begin
            bit pb, bnd;
            pb = mPend[c];
            bnd = s || (e && ((mPos[c] + 1) % mPa[c] == 0));
            if (bnd) begin
                mPos[c] = 0;
                if (pb) begin
                    mPa[c] = mPs[c]; mHa[c] = mHs[c]; mPend[c] = 0;
                end
            end else if (e) begin
                mPos[c] = mPos[c] + 1;
            end
            if (e || s) mDiv[c] = (mPos[c] < mHa[c]);
            mTick[c] = bnd;
            if (w && ch == c && p >= 2) begin
                mPs[c] = p;
                mHs[c] = (h == 0) ? 1 : ((h >= p) ? p - 1 : h);
                mPend[c] = 1;
            end
        end
    endtask

    function automatic logic [NCH-1:0] mvec(input int which);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++)
            v[c] = (which == 0) ? mDiv[c] : ((which == 1) ? mTick[c] : mPend[c]);
        return v;
    endfunction

    task automatic step(input bit e, input bit s, input bit w,
                        input int ch, input int p, input int h);
        en = e; sync = s; wr_en = w;
        wr_ch = CH_W'(ch); wr_period = CNT_W'(p); wr_high = CNT_W'(h);
        @(posedge clk);
        model_edge(e, s, w, ch, p, h);
        #2;
        sync = 0; wr_en = 0;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; sync = 0; wr_en = 0; wr_ch = '0; wr_period = '0; wr_high = '0;
        model_reset();
        #12;
        checks++;
        if ({div_out, tick, pending} !== '0)
            $display("FAIL reset_outputs: got %b required 0", {div_out, tick, pending});
        else passes++;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_defaults();
        for (int k = 0; k <= 2 * RP; k++) begin
            logic [NCH-1:0] et, ed;
            step(1, 0, 0, 0, 0, 0);
            et = (k % RP == 0) ? '1 : '0;
            ed = (k % RP < RH) ? '1 : '0;
            checks++;
            if (tick !== et || div_out !== ed || pending !== '0)
                $display("FAIL defaults k=%0d: got div=%b tick=%b pend=%b required div=%b tick=%b pend=0000",
                         k, div_out, tick, pending, ed, et);
            else passes++;
        end
    endtask

    task automatic test_write_apply();
        int n;
        while (mPos[1] != 99) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 5, 2);
        checks++;
        if (pending !== 4'b0010)
            $display("FAIL write_pending: got %b required 0010", pending);
        else passes++;
        n = 0;
        while (tick[1] !== 1'b1 && n < 1100) begin
            step(1, 0, 0, 0, 0, 0);
            n++;
            checks++;
            if ({div_out, tick, pending} !== {mvec(0), mvec(1), mvec(2)})
                $display("FAIL write_wait: got %b required %b", {div_out, tick, pending},
                         {mvec(0), mvec(1), mvec(2)});
            else passes++;
        end
        checks++;
        if (n !== 924 || pending[1] !== 1'b0)
            $display("FAIL write_apply_latency: got %0d cycles pend=%b required 924 cycles pend=0", n, pending[1]);
        else passes++;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step(1, 0, 0, 0, 0, 0);
            checks++;
            if (div_out[1] !== (i % 5 < 2) || tick[1] !== (i % 5 == 0) ||
                {div_out, tick, pending} !== {mvec(0), mvec(1), mvec(2)})
                $display("FAIL ch1_pattern i=%0d: got div=%b tick=%b required div1=%0d tick1=%0d",
                         i, div_out, tick, (i % 5 < 2), (i % 5 == 0));
            else passes++;
        end
    endtask

    task automatic test_clamp();
        int hi_req [2] = '{0, 7};
        int hi_exp [2] = '{1, 3};
        step(1, 0, 1, 2, 1, 3);
        checks++;
        if (pending[2] !== 1'b0)
            $display("FAIL period1_ignored: got pend2=%b required 0", pending[2]);
        else passes++;
        for (int t = 0; t < 2; t++) begin
            int n;
            step(1, 0, 1, 2, 4, hi_req[t]);
            n = 0;
            while (!(tick[2] === 1'b1 && pending[2] === 1'b0) && n < 1100) begin
                step(1, 0, 0, 0, 0, 0);
                n++;
            end
            checks++;
            if (n >= 1100)
                $display("FAIL clamp_apply_timeout t=%0d: got no apply required apply", t);
            else passes++;
            for (int i = 0; i < 8; i++) begin
                if (i > 0) step(1, 0, 0, 0, 0, 0);
                checks++;
                if (div_out[2] !== (i % 4 < hi_exp[t]) ||
                    {div_out, tick, pending} !== {mvec(0), mvec(1), mvec(2)})
                    $display("FAIL clamp_pattern t=%0d i=%0d: got div2=%b required %0d",
                             t, i, div_out[2], (i % 4 < hi_exp[t]));
                else passes++;
            end
        end
    endtask

    task automatic test_en_hold();
        int n;
        step(1, 0, 1, 0, 6, 3);
        n = 0;
        while (!(tick[0] === 1'b1 && pending[0] === 1'b0) && n < 1100) begin
            step(1, 0, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (n >= 1100) $display("FAIL en_apply_timeout: got no apply required apply");
        else passes++;
        while (mPos[0] != 2) step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if (div_out[0] !== 1'b1 || tick !== '0 ||
                {div_out, tick, pending} !== {mvec(0), mvec(1), mvec(2)})
                $display("FAIL en_low_hold i=%0d: got div=%b tick=%b required div0=1 tick=0000",
                         i, div_out, tick);
            else passes++;
        end
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0, 0, 0, 0);
            checks++;
            if (tick[0] !== (k == 4) || div_out[0] !== (k == 4) ||
                {div_out, tick, pending} !== {mvec(0), mvec(1), mvec(2)})
                $display("FAIL en_resume k=%0d: got tick0=%b div0=%b required %0d", k, tick[0],
                         div_out[0], (k == 4));
            else passes++;
        end
    endtask

    task automatic test_sync();
        step(1, 0, 1, 3, 7, 2);
        checks++;
        if (pending !== 4'b1000)
            $display("FAIL sync_prewrite: got pend=%b required 1000", pending);
        else passes++;
        step(1, 1, 0, 0, 0, 0);
        checks++;
        if (tick !== '1 || div_out !== '1 || pending !== '0)
            $display("FAIL sync_align: got div=%b tick=%b pend=%b required 1111 1111 0000",
                     div_out, tick, pending);
        else passes++;
        step(0, 1, 1, 0, 9, 4);
        checks++;
        if (tick !== '1 || div_out !== '1 || pending !== 4'b0001)
            $display("FAIL sync_with_write: got div=%b tick=%b pend=%b required 1111 1111 0001",
                     div_out, tick, pending);
        else passes++;
        for (int i = 0; i < 30; i++) begin
            step(1, 0, 0, 0, 0, 0);
            checks++;
            if ({div_out, tick, pending} !== {mvec(0), mvec(1), mvec(2)})
                $display("FAIL sync_follow i=%0d: got %b required %b", i,
                         {div_out, tick, pending}, {mvec(0), mvec(1), mvec(2)});
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 1, 0, 3, 1);
        checks++;
        if (pending[0] !== 1'b1)
            $display("FAIL rst_prewrite: got pend0=%b required 1", pending[0]);
        else passes++;
        #3;
        rst = 1;
        #1;
        checks++;
        if (div_out !== '0 || tick !== '0 || pending !== '0)
            $display("FAIL async_reset: got div=%b tick=%b pend=%b required all 0",
                     div_out, tick, pending);
        else passes++;
        model_reset();
        @(negedge clk);
        rst = 0;
        for (int k = 0; k <= RP; k++) begin
            step(1, 0, 0, 0, 0, 0);
            checks++;
            if (tick[0] !== (k % RP == 0) || div_out[0] !== (k % RP < RH) ||
                {div_out, tick, pending} !== {mvec(0), mvec(1), mvec(2)})
                $display("FAIL post_reset k=%0d: got div=%b tick=%b required div0=%0d tick0=%0d",
                         k, div_out, tick, (k % RP < RH), (k % RP == 0));
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bit e, s, w;
            int ch, p, h;
            e  = ($urandom_range(0, 99) < 85);
            s  = ($urandom_range(0, 199) == 0);
            w  = ($urandom_range(0, 9) == 0);
            ch = $urandom_range(0, NCH - 1);
            p  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 20);
            h  = $urandom_range(0, 24);
            step(e, s, w, ch, p, h);
            checks++;
            if ({div_out, tick, pending} !== {mvec(0), mvec(1), mvec(2)})
                $display("FAIL random i=%0d: got div=%b tick=%b pend=%b required div=%b tick=%b pend=%b",
                         i, div_out, tick, pending, mvec(0), mvec(1), mvec(2));
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_write_apply();
        test_clamp();
        test_en_hold();
        test_sync();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Multi-channel programmable clock divider, successor to the fixed power-of-two divider. Each channel generates a divided clock-enable waveform with a runtime-programmable period and high time. Each channel also emits a one-cycle wrap tick. Reprogramming is glitch-free: new settings take effect only at a period boundary. A synchronous restart phase-aligns all channels; it feeds display scan, debounce and sampling logic.

Parameters:
NCH, 4, number of independent divider channels (1..8)
CNT_W, 13, counter/period/high-time width in bits
CH_W, 2, channel-select width; NCH <= 2**CH_W
RST_PERIOD, 1024, per-channel period after reset (2 .. 2**CNT_W-1)
RST_HIGH, 512, per-channel high time after reset (1 .. RST_PERIOD-1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  global count enable
sync  in  1  synchronous restart of all channels
wr_en  in  1  write strobe for channel settings
wr_ch  in  CH_W  target channel of write
wr_period  in  CNT_W  requested period in clk cycles
wr_high  in  CNT_W  requested high time in clk cycles
div_out  out  NCH  registered divided waveform per channel
tick  out  NCH  one-cycle pulse per channel at period start
pending  out  NCH  channel has a written setting not yet applied

Behaviour:
- Per-channel state:
  - shadow period/high (Ps, Hs)
  - active period/high (Pa, Ha)
  - counter cnt
  - pending flag
- Reset (asynchronous, immediate, also mid-operation):
  - Ps=Pa=RST_PERIOD, Hs=Ha=RST_HIGH
  - cnt=RST_PERIOD-1
  - div_out=0, tick=0, pending=0
- Write, on an edge with wr_en=1:
  - wr_ch >= NCH: ignored.
  - wr_period < 2: ignored; shadow and pending unchanged.
  - Otherwise Ps<=wr_period and Hs<=clamp(wr_high); pending[ch]<=1.
  - clamp: 0 -> 1; >= wr_period -> wr_period-1.
- Counting, on an edge with en=1 and sync=0, per channel:
  - If cnt==Pa-1: wrap. cnt<=0, tick<=1.
  - On wrap with pending=1: Pa<=Ps, Ha<=Hs, pending<=0.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - div_out <= (new cnt < new Ha), registered; no combinational path to the output.
- First enabled edge after reset wraps every channel: tick=1 and div_out=1 in cycle 0 of the first period.
- Steady state: div_out is high for Ha cycles, then low for Pa-Ha cycles. tick is high during the cycle where cnt==0.
- en=0: cnt, div_out, Pa, Ha are held; tick<=0. Writes are still accepted; pending applies at the next wrap after en returns.
- sync=1 (any en), all channels at once:
  - cnt<=0, tick<=1
  - pending settings applied (Pa/Ha load, pending<=0)
  - div_out<=1
- Simultaneous write and wrap/sync on the same channel:
  - Wrap/sync applies the pre-write shadow only if pending was already 1.
  - The written value goes to the shadow; pending=1 after the edge.
  - The new value applies at the following wrap.
- Settings change only at cnt==0, so no runt high or low phase is ever produced.
- Counter arithmetic is unsigned CNT_W; Pa >= 2 always, so cnt never exceeds Pa-1.

Test Plan:
- Reset, then en=1 held, defaults -> every channel: tick at cycles 0, 1024, 2048; div_out high cycles 0..511, low 512..1023.
- Write ch1 P=5 H=2 at cnt=100 -> pending[1]=1 until the 1024-cycle period ends. Then ch1 div_out 1,1,0,0,0 repeating, tick every 5 cycles, pending[1]=0. Channels 0,2,3 unchanged.
- Write ch2 P=1 -> ignored, pending[2]=0. Write ch2 P=4 H=0 -> applied H=1 (1,0,0,0). Write ch2 P=4 H=7 -> applied H=3 (1,1,1,0).
- ch0 P=6 H=3, en low 10 cycles at cnt=2 -> div_out frozen at 1, no tick. After en rises, cnt continues 3,4,5,0; next tick exactly 4 enabled cycles later.
- Channels at different phases, pulse sync one cycle -> next cycle all tick=1, all div_out=1, all cnt=0. Pending writes are applied at the same edge.
- Assert rst mid-period with pending[0]=1 -> outputs 0 and pending 0 immediately, without a clock edge. After release and en=1, ch0 runs at RST_PERIOD/RST_HIGH.
